// File: rtl/cache_ctrl_dm128.sv
// Direct-mapped, write-back, write-allocate cache controller: 128 lines x 4 words x 16 bits.
// Tag/valid/dirty state lives here; the data array itself is external and steered by line_sel/word_sel.
module cache_ctrl_dm128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [15:0]  req_addr,
  output logic         done,
  output logic         hit,
  output logic         stall,
  output logic [127:0] line_sel,
  output logic [1:0]   word_sel,
  output logic         data_we,
  output logic         data_src,
  output logic         mem_req,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic         mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WB,
    S_FILL,
    S_UPDATE
  } state_t;

  state_t       state, state_nxt;
  logic [5:0]   lat_tag;
  logic [6:0]   lat_idx;
  logic [1:0]   lat_word;
  logic         lat_we;
  logic [1:0]   word_cnt;
  logic         miss_flag;
  logic [127:0] valid_bits;
  logic [127:0] dirty_bits;
  logic [5:0]   tag_mem [128];
  logic [5:0]   stored_tag;
  logic         line_hit;
  logic         unused_addr_bit;

  assign unused_addr_bit = req_addr[0];
  assign stored_tag      = tag_mem[lat_idx];
  assign line_hit        = valid_bits[lat_idx] && (stored_tag == lat_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_tag    <= '0;
      lat_idx    <= '0;
      lat_word   <= '0;
      lat_we     <= 1'b0;
      word_cnt   <= '0;
      miss_flag  <= 1'b0;
      valid_bits <= '0;
      dirty_bits <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_tag  <= req_addr[15:10];
            lat_idx  <= req_addr[9:3];
            lat_word <= req_addr[2:1];
            lat_we   <= req_we;
          end
        end
        S_COMPARE: begin
          if (line_hit) begin
            miss_flag <= 1'b0;
            if (lat_we) dirty_bits[lat_idx] <= 1'b1;
          end else begin
            word_cnt <= '0;
          end
        end
        // The counter wraps 3 -> 0 on the last ack, so WB hands FILL a zeroed counter.
        S_WB, S_FILL: begin
          if (mem_ack) word_cnt <= word_cnt + 2'd1;
        end
        S_UPDATE: begin
          valid_bits[lat_idx] <= 1'b1;
          dirty_bits[lat_idx] <= 1'b0;
          miss_flag           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the tag array has no reset; a cleared valid bit makes its contents irrelevant.
  always_ff @(posedge clk) begin
    if (!rst && state == S_UPDATE) tag_mem[lat_idx] <= lat_tag;
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    hit       = 1'b0;
    stall     = 1'b0;
    line_sel  = '0;
    word_sel  = '0;
    data_we   = 1'b0;
    data_src  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    if (state != S_IDLE) line_sel = 128'd1 << lat_idx;
    case (state)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (line_hit) begin
          done      = 1'b1;
          hit       = !miss_flag;
          word_sel  = lat_word;
          data_we   = lat_we;
          state_nxt = S_IDLE;
        end else begin
          stall     = 1'b1;
          state_nxt = (valid_bits[lat_idx] && dirty_bits[lat_idx]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {stored_tag, lat_idx, word_cnt, 1'b0};
        word_sel = word_cnt;
        if (mem_ack && word_cnt == 2'd3) state_nxt = S_FILL;
      end
      S_FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {lat_tag, lat_idx, word_cnt, 1'b0};
        word_sel = word_cnt;
        if (mem_ack) begin
          data_we  = 1'b1;
          data_src = 1'b1;
          if (word_cnt == 2'd3) state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        stall     = 1'b1;
        state_nxt = S_COMPARE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_dm128.sv
// Scoreboard bench for cache_ctrl_dm128: a line-level reference model predicts memory traffic
// and done/hit responses; a monitor pops and compares them as the DUT presents them.
module tb_cache_ctrl_dm128;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_we;
  logic [15:0]  req_addr;
  logic         done;
  logic         hit;
  logic         stall;
  logic [127:0] line_sel;
  logic [1:0]   word_sel;
  logic         data_we;
  logic         data_src;
  logic         mem_req;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic         mem_ack;

  cache_ctrl_dm128 dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .done     (done),
    .hit      (hit),
    .stall    (stall),
    .line_sel (line_sel),
    .word_sel (word_sel),
    .data_we  (data_we),
    .data_src (data_src),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
  } mem_op_t;

  typedef struct {
    logic       hit;
    logic       we;
    logic [1:0] word;
    logic [6:0] idx;
  } resp_t;

  mem_op_t exp_mem[$];
  resp_t   exp_resp[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int ack_delay  = 1;
  bit rand_delay = 1'b0;
  int fill_acks  = 0;

  logic       m_valid [128];
  logic       m_dirty [128];
  logic [5:0] m_tag   [128];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  // Line-level behaviour: a miss evicts a dirty line word by word, then fetches the new line.
  task automatic model_access(input logic [15:0] a, input logic we, output logic exp_hit);
    logic [5:0] tag;
    logic [6:0] idx;
    tag = a[15:10];
    idx = a[9:3];
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!exp_hit) begin
      if (m_valid[idx] && m_dirty[idx])
        for (int k = 0; k < 4; k++) exp_mem.push_back('{1'b1, {m_tag[idx], idx, 2'(k), 1'b0}});
      for (int k = 0; k < 4; k++) exp_mem.push_back('{1'b0, {tag, idx, 2'(k), 1'b0}});
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (we) m_dirty[idx] = 1'b1;
    exp_resp.push_back('{exp_hit, we, a[2:1], idx});
  endtask

  // Memory responder: acks each word ack_delay cycles after mem_req is first seen.
  initial begin : responder
    int d;
    bit aborted;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        d = rand_delay ? int'($urandom_range(1, 6)) : ack_delay;
        aborted = 1'b0;
        repeat (d - 1) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!aborted && !rst) begin
          mem_ack = 1'b1;
          @(posedge clk);
          #1;
          mem_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every done pulse and every acked memory word against the queues.
  logic         prev_req = 1'b0;
  logic         prev_ack = 1'b0;
  logic         prev_we  = 1'b0;
  logic [15:0]  prev_addr = '0;
  logic [1:0]   prev_ws = '0;
  resp_t        cur_resp;
  mem_op_t      cur_op;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (done) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_done", 128'(done), 128'(0));
        end else begin
          cur_resp = exp_resp.pop_front();
          check("done_hit", 128'(hit), 128'(cur_resp.hit));
          check("done_data_we", 128'(data_we), 128'(cur_resp.we));
          check("done_word_sel", 128'(word_sel), 128'(cur_resp.word));
          check("done_line_sel", line_sel, 128'd1 << cur_resp.idx);
          check("done_mem_req", 128'(mem_req), 128'(0));
          if (cur_resp.we) check("done_data_src", 128'(data_src), 128'(0));
        end
      end else begin
        check("hit_without_done", 128'(hit), 128'(0));
      end
      if (mem_req) begin
        check("mem_line_sel", line_sel, 128'd1 << mem_addr[9:3]);
        if (prev_req && !prev_ack) begin
          check("hold_mem_addr", 128'(mem_addr), 128'(prev_addr));
          check("hold_mem_we", 128'(mem_we), 128'(prev_we));
          check("hold_word_sel", 128'(word_sel), 128'(prev_ws));
        end
        if (mem_ack) begin
          if (exp_mem.size() == 0) begin
            check("unexpected_mem_op", 128'(mem_req), 128'(0));
          end else begin
            cur_op = exp_mem.pop_front();
            check("mem_we", 128'(mem_we), 128'(cur_op.we));
            check("mem_addr", 128'(mem_addr), 128'(cur_op.addr));
            check("mem_word_sel", 128'(word_sel), 128'(cur_op.addr[2:1]));
            if (!cur_op.we) begin
              check("fill_data_we", 128'(data_we), 128'(1));
              check("fill_data_src", 128'(data_src), 128'(1));
              fill_acks++;
            end else begin
              check("wb_data_we", 128'(data_we), 128'(0));
            end
          end
        end
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_we   = mem_we;
      prev_addr = mem_addr;
      prev_ws   = word_sel;
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_hit"}, 128'(hit), 128'(0));
    check({tag, "_stall"}, 128'(stall), 128'(0));
    check({tag, "_mem_req"}, 128'(mem_req), 128'(0));
    check({tag, "_data_we"}, 128'(data_we), 128'(0));
    check({tag, "_line_sel"}, line_sel, 128'(0));
    check({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    exp_mem.delete();
    exp_resp.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
  endtask

  // One CPU access; inputs are scrambled once the request is latched.
  task automatic do_access(input logic [15:0] a, input logic we);
    logic eh;
    int   n;
    bit   got;
    model_access(a, we, eh);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    n   = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      check("stall", 128'(stall), 128'(!done));
      if (done) got = 1'b1;
      if (n >= 2) begin
        req_addr = 16'($urandom);
        req_we   = 1'($urandom);
      end
    end
    if (!got) check("done_timeout", 128'(n), 128'(0));
    else if (eh) check("hit_latency", 128'(n), 128'(2));
  endtask

  task automatic go_idle(input int cycles);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  initial begin : stimulus
    int   n;
    int   base;
    logic eh;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    do_reset();

    // Fill, hit, write hit, then a dirty eviction on the same index.
    ack_delay = 1;
    do_access(16'h0408, 1'b0);
    go_idle(1);
    do_access(16'h040A, 1'b0);
    do_access(16'h040C, 1'b1);
    do_access(16'h0808, 1'b0);
    go_idle(2);

    // Slow memory: five cycles per word.
    ack_delay = 5;
    do_access(16'h0C12, 1'b1);
    do_access(16'h1010, 1'b0);
    go_idle(2);

    // Randomized traffic over a small tag/index space to force conflicts.
    rand_delay = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do_access({6'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), 2'($urandom), 1'($urandom)},
                1'($urandom));
      if ($urandom_range(0, 3) == 0) go_idle($urandom_range(0, 3));
    end
    go_idle(2);
    rand_delay = 1'b0;

    // Reset during a fill, after two words have arrived.
    do_reset();
    ack_delay = 3;
    base = fill_acks;
    model_access(16'h0408, 1'b0, eh);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 16'h0408;
    req_we    = 1'b0;
    n = 0;
    while (fill_acks < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_two_acks", 128'(fill_acks - base), 128'(2));
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    exp_mem.delete();
    exp_resp.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    ack_delay = 1;
    do_access(16'h0408, 1'b0);
    go_idle(3);

    check("exp_mem_drained", 128'(exp_mem.size()), 128'(0));
    check("exp_resp_drained", 128'(exp_resp.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
